// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 register file with precise exception/interrupt arbitration, Count/Compare timer and ERET.
//   clk, reset (sync, active-low); src_valid/src_code/src_pc/src_bd/src_bva per-stage exception requests;
//   int_ok/int_pc/int_bd interrupt attach point; hw_int external IRQs; eret return request;
//   cp0_we/cp0_addr/cp0_sel/cp0_wdata MTC0; cp0_rdata MFC0; flush/redirect_pc pipeline redirect; status_o/cause_o.
module cp0_exc_ctrl #(
    parameter int          N_SRC      = 4,
    parameter int          N_HW_INT   = 6,
    parameter bit          TIMER_EN   = 1'b1,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      src_valid,
    input  logic [5*N_SRC-1:0]    src_code,
    input  logic [32*N_SRC-1:0]   src_pc,
    input  logic [N_SRC-1:0]      src_bd,
    input  logic [32*N_SRC-1:0]   src_bva,
    input  logic                  int_ok,
    input  logic [31:0]           int_pc,
    input  logic                  int_bd,
    input  logic [N_HW_INT-1:0]   hw_int,
    input  logic                  eret,
    input  logic                  cp0_we,
    input  logic [4:0]            cp0_addr,
    input  logic [2:0]            cp0_sel,
    input  logic [31:0]           cp0_wdata,
    output logic [31:0]           cp0_rdata,
    output logic                  flush,
    output logic [31:0]           redirect_pc,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o
);
    logic [7:0]  im;
    logic        exl, ie, bd, ti, tog;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [31:0] epc, bad_va, count, compare, count_inc;
    logic [7:0]  ip;
    logic        int_pend, take, take_eret, wr, w_bd;
    logic [4:0]  w_code;
    logic [31:0] w_pc, w_bva;

    assign ip        = {ip_hw[5] | (TIMER_EN & ti), ip_hw[4:0], ip_sw};
    assign status_o  = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause_o   = {bd, ti, 14'b0, ip, 1'b0, exc_code, 2'b0};
    assign int_pend  = ie & ~exl & |(ip & im) & int_ok;
    assign wr        = cp0_we & (cp0_sel == 3'd0) & ~flush & ~take & ~take_eret;
    assign count_inc = count + 32'd1;

    assign cp0_rdata = (cp0_sel != 3'd0) ? 32'd0 :
                       (cp0_addr == 5'd8)  ? bad_va :
                       (cp0_addr == 5'd9)  ? count :
                       (cp0_addr == 5'd11) ? compare :
                       (cp0_addr == 5'd12) ? status_o :
                       (cp0_addr == 5'd13) ? cause_o :
                       (cp0_addr == 5'd14) ? epc : 32'd0;

    // ERET sits between the oldest stage and the younger ones; the ascending loop lets the highest index win.
    always_comb begin
        take      = 1'b0;
        take_eret = 1'b0;
        w_code    = 5'd0;
        w_pc      = int_pc;
        w_bd      = int_bd;
        w_bva     = 32'd0;
        if (!flush) begin
            if (int_pend) begin
                take = 1'b1;
            end else if (src_valid[N_SRC-1]) begin
                take   = 1'b1;
                w_code = src_code[5*(N_SRC-1) +: 5];
                w_pc   = src_pc[32*(N_SRC-1) +: 32];
                w_bd   = src_bd[N_SRC-1];
                w_bva  = src_bva[32*(N_SRC-1) +: 32];
            end else if (eret) begin
                take_eret = 1'b1;
            end else begin
                for (int i = 0; i < N_SRC-1; i++) begin
                    if (src_valid[i]) begin
                        take   = 1'b1;
                        w_code = src_code[5*i +: 5];
                        w_pc   = src_pc[32*i +: 32];
                        w_bd   = src_bd[i];
                        w_bva  = src_bva[32*i +: 32];
                    end
                end
            end
        end
    end

    // Software writes come last so a Count/Compare write overrides the timer update of the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im          <= 8'd0;
            exl         <= 1'b0;
            ie          <= 1'b0;
            bd          <= 1'b0;
            ti          <= 1'b0;
            tog         <= 1'b0;
            ip_hw       <= 6'd0;
            ip_sw       <= 2'd0;
            exc_code    <= 5'd0;
            epc         <= 32'd0;
            bad_va      <= 32'd0;
            count       <= 32'd0;
            compare     <= 32'd0;
            flush       <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            ip_hw <= 6'(hw_int);
            tog   <= ~tog;
            if (tog) begin
                count <= count_inc;
                if (count_inc == compare) ti <= 1'b1;
            end
            flush <= take | take_eret;
            if (take) begin
                if (!exl) begin
                    epc <= w_bd ? w_pc - 32'd4 : w_pc;
                    bd  <= w_bd;
                end
                exc_code    <= w_code;
                exl         <= 1'b1;
                redirect_pc <= EXC_VECTOR;
                if (w_code == 5'd4 || w_code == 5'd5) bad_va <= w_bva;
            end
            if (take_eret) begin
                exl         <= 1'b0;
                redirect_pc <= epc;
            end
            if (wr) begin
                case (cp0_addr)
                    5'd9: begin
                        count <= cp0_wdata;
                        tog   <= 1'b0;
                    end
                    5'd11: begin
                        compare <= cp0_wdata;
                        ti      <= 1'b0;
                    end
                    5'd12: begin
                        im  <= cp0_wdata[15:8];
                        exl <= cp0_wdata[1];
                        ie  <= cp0_wdata[0];
                    end
                    5'd13: ip_sw <= cp0_wdata[9:8];
                    5'd14: epc <= cp0_wdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed and randomized bench for cp0_exc_ctrl against a per-cycle reference model.
module tb_cp0_exc_ctrl;
    localparam int          N   = 4;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    src_valid, src_bd;
    logic [5*N-1:0]  src_code;
    logic [32*N-1:0] src_pc, src_bva;
    logic            int_ok, int_bd, eret, cp0_we, flush;
    logic [31:0]     int_pc, cp0_wdata, cp0_rdata, redirect_pc, status_o, cause_o;
    logic [5:0]      hw_int;
    logic [4:0]      cp0_addr;
    logic [2:0]      cp0_sel;
    int              tests = 0, fails = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_code(src_code), .src_pc(src_pc),
        .src_bd(src_bd), .src_bva(src_bva), .int_ok(int_ok), .int_pc(int_pc), .int_bd(int_bd),
        .hw_int(hw_int), .eret(eret), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_sel(cp0_sel),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .flush(flush), .redirect_pc(redirect_pc),
        .status_o(status_o), .cause_o(cause_o)
    );

    logic [31:0] m_epc, m_bva, m_count, m_cmp, m_redir;
    logic [7:0]  m_im;
    logic [5:0]  m_hw;
    logic [1:0]  m_sw;
    logic [4:0]  m_code;
    logic        m_ie, m_exl, m_bd, m_ti, m_tog, m_flush;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        {m_epc, m_bva, m_count, m_cmp, m_redir} = '0;
        {m_im, m_hw, m_sw, m_code} = '0;
        {m_ie, m_exl, m_bd, m_ti, m_tog, m_flush} = '0;
    endtask

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
        if (s != 0) return 0;
        case (a)
            8:  return m_bva;
            9:  return m_count;
            11: return m_cmp;
            12: return m_status();
            13: return m_cause();
            14: return m_epc;
            default: return 0;
        endcase
    endfunction

    // Priority list: 100 = interrupt, 200 = ERET, otherwise a source index.
    task automatic m_step();
        int          prio[6];
        int          win;
        logic        pend, wr_ok, bd;
        logic [31:0] old_epc, pc, bva;
        logic [4:0]  code;
        if (!reset) begin
            m_reset();
            return;
        end
        prio    = '{100, 3, 200, 2, 1, 0};
        win     = -1;
        old_epc = m_epc;
        pend    = m_ie && !m_exl && ((m_ip() & m_im) != 0) && int_ok;
        if (!m_flush)
            for (int k = 0; k < 6 && win < 0; k++)
                if (prio[k] == 100) begin
                    if (pend) win = 100;
                end else if (prio[k] == 200) begin
                    if (eret) win = 200;
                end else if (src_valid[prio[k]]) win = prio[k];
        wr_ok = cp0_we && cp0_sel == 0 && !m_flush && win < 0;
        m_hw  = hw_int;
        if (wr_ok && cp0_addr == 9) begin
            m_count = cp0_wdata;
            m_tog   = 0;
        end else begin
            if (m_tog) begin
                m_count = m_count + 1;
                if (m_count == m_cmp) m_ti = 1;
            end
            m_tog = !m_tog;
        end
        if (wr_ok && cp0_addr == 11) begin
            m_cmp = cp0_wdata;
            m_ti  = 0;
        end
        if (wr_ok && cp0_addr == 12) begin
            m_im  = cp0_wdata[15:8];
            m_exl = cp0_wdata[1];
            m_ie  = cp0_wdata[0];
        end
        if (wr_ok && cp0_addr == 13) m_sw = cp0_wdata[9:8];
        if (wr_ok && cp0_addr == 14) m_epc = cp0_wdata;
        m_flush = win >= 0;
        if (win == 200) begin
            m_exl   = 0;
            m_redir = old_epc;
        end else if (win >= 0) begin
            if (win == 100) begin
                code = 0; pc = int_pc; bd = int_bd; bva = 0;
            end else begin
                code = src_code[5*win +: 5]; pc = src_pc[32*win +: 32];
                bd = src_bd[win]; bva = src_bva[32*win +: 32];
            end
            if (!m_exl) begin
                m_epc = bd ? pc - 4 : pc;
                m_bd  = bd;
            end
            m_code = code;
            m_exl  = 1;
            if (code == 4 || code == 5) m_bva = bva;
            m_redir = VEC;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("flush", 32'(flush), 32'(m_flush));
        chk("redirect", redirect_pc, m_redir);
        chk("status", status_o, m_status());
        chk("cause", cause_o, m_cause());
        chk("rdata", cp0_rdata, m_read(cp0_addr, cp0_sel));
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1; src_valid = 0; src_bd = 0; src_code = 0; src_pc = 0; src_bva = 0;
        int_ok = 0; int_pc = 0; int_bd = 0; hw_int = 0; eret = 0;
        cp0_we = 0; cp0_addr = 0; cp0_sel = 0; cp0_wdata = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        cyc();
        cyc();
        reset = 1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1; cp0_addr = a; cp0_wdata = d;
        cyc();
        cp0_we = 0;
    endtask

    initial begin
        logic [4:0] addrs[7];
        addrs = '{8, 9, 11, 12, 13, 14, 3};
        idle();
        reset = 0;
        m_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        rd("rst_mfc0_status", 12, 32'h0040_0000);

        src_valid = 4'b0010; src_code[5 +: 5] = 12; src_pc[32 +: 32] = 32'h100;
        cyc();
        idle();
        chk("exc_flush", 32'(flush), 32'd1);
        chk("exc_redirect", redirect_pc, VEC);
        rd("exc_epc", 14, 32'h100);
        chk("exc_code", 32'(cause_o[6:2]), 32'd12);
        chk("exc_exl", 32'(status_o[1]), 32'd1);
        cyc();
        chk("exc_flush_drop", 32'(flush), 32'd0);

        do_reset();
        src_valid = 4'b1001;
        src_code[15 +: 5] = 4; src_pc[96 +: 32] = 32'h200; src_bd[3] = 1; src_bva[96 +: 32] = 32'h3;
        src_code[0 +: 5] = 4; src_pc[0 +: 32] = 32'h50; src_bva[0 +: 32] = 32'h77;
        cyc();
        idle();
        rd("mem_epc", 14, 32'h1FC);
        chk("mem_bd", 32'(cause_o[31]), 32'd1);
        rd("mem_badva", 8, 32'h3);
        cyc();
        eret = 1; src_valid[3] = 1; src_code[15 +: 5] = 12; src_pc[96 +: 32] = 32'h400;
        cyc();
        idle();
        chk("eret_lose_redirect", redirect_pc, VEC);
        rd("eret_lose_epc", 14, 32'h1FC);
        chk("eret_lose_exl", 32'(status_o[1]), 32'd1);
        cyc();
        eret = 1;
        cyc();
        idle();
        chk("eret_flush", 32'(flush), 32'd1);
        chk("eret_redirect", redirect_pc, 32'h1FC);
        chk("eret_exl", 32'(status_o[1]), 32'd0);
        cyc();

        do_reset();
        src_valid = 4'b0010; src_pc[32 +: 32] = 32'h100;
        cp0_we = 1; cp0_addr = 14; cp0_wdata = 32'hDEAD;
        cyc();
        src_valid = 4'b1000; eret = 1; cp0_wdata = 32'h55;
        cyc();
        idle();
        chk("drop_flush", 32'(flush), 32'd0);
        rd("drop_epc", 14, 32'h100);

        src_valid = 4'b0001;
        cyc();
        idle();
        reset = 0;
        cyc();
        reset = 1;
        chk("rst_mid_flush", 32'(flush), 32'd0);
        chk("rst_mid_status", status_o, 32'h0040_0000);

        do_reset();
        wr(12, 32'h8001);
        wr(11, 10);
        wr(9, 0);
        int_ok = 1; int_pc = 32'h300;
        for (int k = 0; k < 60 && !flush; k++) cyc();
        int_ok = 0;
        chk("timer_flush", 32'(flush), 32'd1);
        chk("timer_code", 32'(cause_o[6:2]), 32'd0);
        chk("timer_ti", 32'(cause_o[30]), 32'd1);
        rd("timer_epc", 14, 32'h300);
        cyc();
        wr(11, 32'h1000);
        chk("timer_ti_clear", 32'(cause_o[30]), 32'd0);

        for (int n = 0; n < 4000; n++) begin
            reset    = $urandom_range(0, 199) != 0;
            for (int i = 0; i < N; i++) begin
                src_valid[i]      = $urandom_range(0, 9) == 0;
                src_bd[i]         = 1'($urandom);
                src_code[5*i +: 5] = 5'($urandom_range(0, 7));
                src_pc[32*i +: 32] = $urandom;
                src_bva[32*i +: 32] = $urandom;
            end
            int_ok    = 1'($urandom);
            int_pc    = $urandom;
            int_bd    = 1'($urandom);
            hw_int    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            eret      = $urandom_range(0, 9) == 0;
            cp0_we    = $urandom_range(0, 3) == 0;
            cp0_addr  = addrs[$urandom_range(0, 6)];
            cp0_sel   = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0;
            cp0_wdata = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
            cyc();
        end
        idle();
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
